// File: rtl/decstage_if.sv
// Decode-stage bus interface.
// Carries the fetched instruction, the write-back controls and candidates,
// and the decode results (extended immediate and two register operands).
//   master : the side that drives instr / write-back controls (pipeline control)
//   slave  : the decode stage itself
interface decstage_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       instr;
    logic              RF_WrEn;
    logic              RF_WrData_sel;
    logic              RF_B_sel;
    logic [DATA_W-1:0] ALU_out;
    logic [DATA_W-1:0] MEM_out;
    logic [31:0]       Immed;
    logic [DATA_W-1:0] RF_A;
    logic [DATA_W-1:0] RF_B;

    modport master (
        output instr, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_out, MEM_out,
        input  Immed, RF_A, RF_B
    );

    modport slave (
        input  instr, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_out, MEM_out,
        output Immed, RF_A, RF_B
    );
endinterface

// File: rtl/decstage.sv
// Instruction-decode stage.
// Decodes the fetched instruction, reads two operands from a 2**ADDR_W x DATA_W
// register file (combinational reads, R0 hardwired to zero), extends the
// immediate according to the opcode, and commits write-back data to register rd
// on the rising clock edge.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high, clears every register (wins over a write)
//   bus   : decstage_if.slave -- instr, RF_WrEn, RF_WrData_sel, RF_B_sel,
//           ALU_out, MEM_out in; Immed, RF_A, RF_B out
module decstage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    decstage_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [5:0]        opcode_s;
    logic [ADDR_W-1:0] rs_s;
    logic [ADDR_W-1:0] rd_s;
    logic [ADDR_W-1:0] rt_s;
    logic [ADDR_W-1:0] rb_addr_s;
    logic [15:0]       imm16_s;
    logic [31:0]       sext_s;
    logic [31:0]       immed_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic [DATA_W-1:0] rf_r [NREG];

    // Field decode, port-B address select and write-data select
    always_comb begin
        opcode_s  = bus.instr[31:26];
        rs_s      = bus.instr[25:21];
        rd_s      = bus.instr[20:16];
        rt_s      = bus.instr[15:11];
        imm16_s   = bus.instr[15:0];
        sext_s    = {{16{bus.instr[15]}}, bus.instr[15:0]};
        if (bus.RF_B_sel) begin
            rb_addr_s = rd_s;
        end else begin
            rb_addr_s = rt_s;
        end
        if (bus.RF_WrData_sel) begin
            wr_data_s = bus.MEM_out;
        end else begin
            wr_data_s = bus.ALU_out;
        end
    end

    // Asynchronous register reads; address 0 always reads zero regardless of storage
    always_comb begin
        rf_a_s = {DATA_W{1'b0}};
        rf_b_s = {DATA_W{1'b0}};
        if (rs_s != {ADDR_W{1'b0}}) begin
            rf_a_s = rf_r[rs_s];
        end else begin
            rf_a_s = {DATA_W{1'b0}};
        end
        if (rb_addr_s != {ADDR_W{1'b0}}) begin
            rf_b_s = rf_r[rb_addr_s];
        end else begin
            rf_b_s = {DATA_W{1'b0}};
        end
    end

    // Immediate extension selected by opcode; unknown opcodes sign-extend so the
    // value stays deterministic
    always_comb begin
        immed_s = sext_s;
        case (opcode_s)
            6'b111000, 6'b110000, 6'b000011,
            6'b001111, 6'b000111, 6'b011111: immed_s = sext_s;
            6'b110010, 6'b110011:            immed_s = {16'h0000, imm16_s};
            6'b111001:                       immed_s = {imm16_s, 16'h0000};
            // branch offsets are word offsets; top two bits fall off
            6'b111111, 6'b000000, 6'b000001: immed_s = {sext_s[29:0], 2'b00};
            default:                         immed_s = sext_s;
        endcase
    end

    // Register-file update: reset clears everything and drops a coincident write;
    // writes to R0 are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else if (bus.RF_WrEn && (rd_s != {ADDR_W{1'b0}})) begin
            rf_r[rd_s] <= wr_data_s;
        end
    end

    assign bus.Immed = immed_s;
    assign bus.RF_A  = rf_a_s;
    assign bus.RF_B  = rf_b_s;
endmodule

// File: tb/tb_decstage.sv
// Self-checking bench for decstage: directed test-plan cases followed by a
// randomized run, all compared against a register-array reference model.
module tb_decstage;
    logic clk;
    logic reset;

    decstage_if #(.DATA_W(32)) bus ();

    decstage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_bad;
    logic [31:0] model [32];

    // current stimulus, kept by the bench so the model never reads the DUT
    logic [31:0] cur_instr;
    logic        cur_we;
    logic        cur_ws;
    logic        cur_bs;
    logic [31:0] cur_alu;
    logic [31:0] cur_mem;
    logic        cur_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rd,
                                       input logic [15:0] imm);
        logic [4:0] a;
        logic [4:0] b;
        a = rs[4:0];
        b = rd[4:0];
        return {op, a, b, imm};
    endfunction

    // expected immediate from the opcode's extension rule, via integer arithmetic
    function automatic logic [31:0] exp_immed(input logic [31:0] ins);
        int          s;
        int unsigned u;
        s = ins[15] ? int'(ins[15:0]) - 65536 : int'(ins[15:0]);
        u = int'(ins[15:0]);
        case (ins[31:26])
            6'o70, 6'o60, 6'o03, 6'o17, 6'o07, 6'o37: return s;
            6'o62, 6'o63:                             return u;
            6'o71:                                    return u * 65536;
            6'o77, 6'o00, 6'o01:                      return s * 4;
            default:                                  return s;
        endcase
    endfunction

    // drive one cycle's inputs and compare all outputs against the model
    task automatic apply(input logic [31:0] ins, input logic we, input logic ws,
                         input logic bs, input logic [31:0] alu, input logic [31:0] mem,
                         input logic rst);
        int ra;
        int rb;
        cur_instr = ins; cur_we = we; cur_ws = ws; cur_bs = bs;
        cur_alu = alu; cur_mem = mem; cur_rst = rst;
        bus.instr = ins; bus.RF_WrEn = we; bus.RF_WrData_sel = ws; bus.RF_B_sel = bs;
        bus.ALU_out = alu; bus.MEM_out = mem; reset = rst;
        #1;
        ra = int'(ins[25:21]);
        rb = bs ? int'(ins[20:16]) : int'(ins[15:11]);
        check("RF_A", bus.RF_A, model[ra]);
        check("RF_B", bus.RF_B, model[rb]);
        check("Immed", bus.Immed, exp_immed(ins));
    endtask

    // advance one clock edge and commit the same effect into the model
    task automatic tick();
        int rd;
        @(posedge clk);
        rd = int'(cur_instr[20:16]);
        if (cur_rst) begin
            foreach (model[k]) model[k] = 32'h0;
        end else if (cur_we && rd != 0) begin
            model[rd] = cur_ws ? cur_mem : cur_alu;
        end
        #1;
    endtask

    logic [5:0] ops [12];

    initial begin
        n_vec = 0;
        n_bad = 0;
        ops = '{6'o70, 6'o60, 6'o03, 6'o17, 6'o07, 6'o37,
                6'o62, 6'o63, 6'o71, 6'o77, 6'o00, 6'o40};
        bus.instr = 32'h0; bus.RF_WrEn = 1'b0; bus.RF_WrData_sel = 1'b0;
        bus.RF_B_sel = 1'b0; bus.ALU_out = 32'h0; bus.MEM_out = 32'h0;
        reset = 1'b1;
        cur_instr = 32'h0; cur_we = 1'b0; cur_ws = 1'b0; cur_bs = 1'b0;
        cur_alu = 32'h0; cur_mem = 32'h0; cur_rst = 1'b1;

        // reset held for two edges
        @(posedge clk); @(posedge clk); #1;
        foreach (model[k]) model[k] = 32'h0;

        // reset then read
        apply(32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("reset_rfa", bus.RF_A, 32'h0);
        check("reset_rfb", bus.RF_B, 32'h0);
        tick();

        // write then read back
        apply(mk(6'o40, 0, 5, 16'h0), 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tick();
        apply(mk(6'o40, 5, 5, 16'h0), 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("wr_rfa", bus.RF_A, 32'hDEAD_BEEF);
        check("wr_rfb", bus.RF_B, 32'hDEAD_BEEF);
        tick();

        // R0 protection
        apply(mk(6'o40, 0, 0, 16'h0), 1'b1, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
        tick();
        apply(mk(6'o40, 0, 0, 16'h0), 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("r0_rfa", bus.RF_A, 32'h0);
        tick();

        // immediate extension with imm16 = 0x8001
        apply(mk(6'b110000, 0, 0, 16'h8001), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("imm_addi", bus.Immed, 32'hFFFF_8001);
        apply(mk(6'b110011, 0, 0, 16'h8001), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("imm_ori", bus.Immed, 32'h0000_8001);
        apply(mk(6'b111001, 0, 0, 16'h8001), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("imm_lui", bus.Immed, 32'h8001_0000);
        apply(mk(6'b000000, 0, 0, 16'h8001), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("imm_beq", bus.Immed, 32'hFFFE_0004);
        tick();

        // reset vs write collision
        apply(mk(6'o40, 0, 7, 16'h0), 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 1'b0);
        tick();
        apply(mk(6'o40, 7, 7, 16'h0), 1'b1, 1'b0, 1'b1, 32'hAA, 32'h0, 1'b1);
        check("coll_pre", bus.RF_A, 32'h55);
        tick();
        apply(mk(6'o40, 7, 5, 16'h0), 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("coll_r7", bus.RF_A, 32'h0);
        check("coll_r5", bus.RF_B, 32'h0);
        tick();

        // read during write
        apply(mk(6'o40, 0, 3, 16'h0), 1'b1, 1'b0, 1'b0, 32'h11, 32'h0, 1'b0);
        tick();
        apply(mk(6'o40, 3, 3, 16'h0), 1'b1, 1'b0, 1'b0, 32'h22, 32'h0, 1'b0);
        check("rdw_old", bus.RF_A, 32'h11);
        tick();
        apply(mk(6'o40, 3, 3, 16'h0), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rdw_new", bus.RF_A, 32'h22);
        tick();

        // randomized traffic, addresses biased to a small set so reads hit writes
        for (int it = 0; it < 600; it++) begin
            logic [5:0]  op;
            int          rs;
            int          rd;
            logic [15:0] imm;
            op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            rs  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            rd  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            imm = 16'($urandom);
            apply(mk(op, rs, rd, imm), 1'($urandom_range(0, 2) != 0), 1'($urandom),
                  1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 59) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
